rambit_arb: RTL and testbench

- Two-requester arbiter and sequencer for one single-port, per-bit-masked synchronous RAM: chip enable, bit write mask, address, data in, 1-cycle registered read data out.
- Grants one access per cycle using round-robin and routes the read data back to the requester that was granted.
- Optionally clears the whole RAM after reset, before any requester access.
- Sits between two client pipelines and the RAM macro or generic RAM model.

---
 rtl/rambit_arb_pkg.sv | 19 +
 rtl/rambit_arb_rr2.sv | 32 +++
 rtl/rambit_arb.sv | 130 +++++++++++++
 tb/tb_rambit_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rambit_arb_pkg.sv
// Shared encodings for the rambit arbiter family: FSM states, requester ids and depth helper.
package rambit_pkg;

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  typedef enum logic {
    ReqA = 1'b0,
    ReqB = 1'b1
  } req_id_e;

  localparam int unsigned AW_DEFAULT = 10;
  localparam int unsigned DEPTH      = 2 ** AW_DEFAULT;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/rambit_arb_rr2.sv
// Two-way round-robin grant; the pointer remembers the most recently granted requester.
module rambit_rr2
  import rambit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  req_id_e r_last;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b00:   o_gnt = 2'b00;
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      default: o_gnt = (r_last == ReqB) ? 2'b01 : 2'b10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ReqB;
    end else if (i_adv && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1] ? ReqB : ReqA;
    end
  end

endmodule

// File: rtl/rambit_arb.sv
// Two-requester round-robin sequencer for a bit-masked single-port RAM with 1-cycle read data.
// Define RAMBIT_ARB_INIT_EN to clear the whole RAM after reset before accepting requests.
module rambit_arb
  import rambit_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,

  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,

  output logic          ram_ce,
  output logic [DW-1:0] ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,

  output logic          init_done
);

  logic          w_state;
  logic          w_sweep;
  logic [AW-1:0] w_cnt;
  logic          w_run;
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          r_pend_v;
  req_id_e       r_pend_id;

`ifdef RAMBIT_ARB_INIT_EN
  localparam logic [AW-1:0] CntLast = AW'(depth_of(AW) - 1);

  logic          r_state;
  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else if (r_state == StInit) begin
      if (r_cnt == CntLast) begin
        r_state <= StRun;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_state = r_state;
  assign w_sweep = (r_state == StInit) && !rst;
  assign w_cnt   = r_cnt;
`else
  assign w_state = StRun;
  assign w_sweep = 1'b0;
  assign w_cnt   = '0;
`endif

  // Reset gates the request path combinationally so nothing leaks while rst is held.
  assign w_run     = (w_state == StRun) && !rst;
  assign w_req     = {b_valid, a_valid} & {2{w_run}};
  assign init_done = (w_state == StRun);

  rambit_rr2 u_rr2 (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_adv (w_run),
    .o_gnt (w_gnt)
  );

  assign a_ready = w_gnt[0];
  assign b_ready = w_gnt[1];

  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_sweep) begin
      ram_ce   = 1'b1;
      ram_we   = '1;
      ram_addr = w_cnt;
    end else if (w_gnt[0]) begin
      ram_ce   = 1'b1;
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (w_gnt[1]) begin
      ram_ce   = 1'b1;
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_v  <= 1'b0;
      r_pend_id <= ReqA;
    end else begin
      r_pend_v <= (w_gnt != 2'b00);
      if (w_gnt != 2'b00) begin
        r_pend_id <= w_gnt[1] ? ReqB : ReqA;
      end
    end
  end

  // Writes also answer, carrying the pre-write word the RAM reads out.
  assign a_rvalid = r_pend_v && (r_pend_id == ReqA);
  assign b_rvalid = r_pend_v && (r_pend_id == ReqB);
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_rambit_arb.sv
// Randomized bench for rambit_arb against a word-level memory and round-robin model.
module tb_rambit_arb;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [DW-1:0] a_we = '0, a_din = '0, b_we = '0, b_din = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_ce;
  logic [DW-1:0] ram_we, ram_din;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          init_done;

  always #5 clk = ~clk;

  rambit_arb #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_din     (a_din),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_din     (b_din),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  // Environment RAM: read-before-write, per-bit mask.
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_dout      <= mem[ram_addr];
      mem[ram_addr] <= (mem[ram_addr] & ~ram_we) | (ram_din & ram_we);
    end
  end

  // Reference model state
  logic [DW-1:0] exp_mem [DEPTH] = '{default: '0};
  bit            exp_last = 1'b1;  // 1: B granted most recently
  bit            exp_pv   = 1'b0;
  bit            exp_pid  = 1'b0;
  logic [DW-1:0] exp_pdata = '0;
  logic [DW-1:0] obs_a_rdata, obs_b_rdata;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(
    input  logic av, input logic [DW-1:0] awe, input logic [AW-1:0] aaddr,
    input  logic [DW-1:0] adin,
    input  logic bv, input logic [DW-1:0] bwe, input logic [AW-1:0] baddr,
    input  logic [DW-1:0] bdin,
    output logic ra, output logic rb
  );
    bit            ga, gb;
    logic [DW-1:0] we, din;
    logic [AW-1:0] addr;
    @(negedge clk);
    obs_a_rdata = a_rdata;
    obs_b_rdata = b_rdata;
    check_eq("a_rvalid", 32'(a_rvalid), 32'(exp_pv && !exp_pid));
    check_eq("b_rvalid", 32'(b_rvalid), 32'(exp_pv && exp_pid));
    check_eq("a_rdata", a_rdata, (exp_pv && !exp_pid) ? exp_pdata : 32'h0);
    check_eq("b_rdata", b_rdata, (exp_pv && exp_pid) ? exp_pdata : 32'h0);
    exp_pv = 1'b0;
    a_valid = av; a_we = awe; a_addr = aaddr; a_din = adin;
    b_valid = bv; b_we = bwe; b_addr = baddr; b_din = bdin;
    #1;
    ga = av && (!bv || exp_last);
    gb = bv && !ga;
    we   = ga ? awe : (gb ? bwe : '0);
    din  = ga ? adin : (gb ? bdin : '0);
    addr = ga ? aaddr : (gb ? baddr : '0);
    check_eq("init_done", 32'(init_done), 32'h1);
    check_eq("a_ready", 32'(a_ready), 32'(ga));
    check_eq("b_ready", 32'(b_ready), 32'(gb));
    check_eq("ram_ce", 32'(ram_ce), 32'(ga || gb));
    check_eq("ram_we", ram_we, we);
    check_eq("ram_addr", 32'(ram_addr), 32'(addr));
    check_eq("ram_din", ram_din, din);
    if (ga || gb) begin
      exp_pdata     = exp_mem[addr];
      exp_mem[addr] = (exp_mem[addr] & ~we) | (din & we);
      exp_pv        = 1'b1;
      exp_pid       = gb;
      exp_last      = gb;
    end
    ra = a_ready;
    rb = b_ready;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    exp_pv   = 1'b0;  // in-flight response is dropped
    exp_last = 1'b1;
    #1;
    check_eq("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    check_eq("rst_b_rvalid", 32'(b_rvalid), 32'h0);
    check_eq("rst_a_rdata", a_rdata, 32'h0);
    check_eq("rst_b_rdata", b_rdata, 32'h0);
    check_eq("rst_a_ready", 32'(a_ready), 32'h0);
    check_eq("rst_b_ready", 32'(b_ready), 32'h0);
    check_eq("rst_ram_ce", 32'(ram_ce), 32'h0);
`ifdef RAMBIT_ARB_INIT_EN
    check_eq("rst_init_done", 32'(init_done), 32'h0);
`else
    check_eq("rst_init_done", 32'(init_done), 32'h1);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef RAMBIT_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_eq("sweep_ce", 32'(ram_ce), 32'h1);
      check_eq("sweep_addr", 32'(ram_addr), 32'(i));
      check_eq("sweep_we", ram_we, 32'hFFFF_FFFF);
      check_eq("sweep_din", ram_din, 32'h0);
      check_eq("sweep_ready", 32'({a_ready, b_ready}), 32'h0);
      check_eq("sweep_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
      check_eq("sweep_init_done", 32'(init_done), 32'h0);
    end
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
`endif
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  logic          ra, rb;
  logic [7:0]    seq;
  logic          pav, pbv;
  logic [DW-1:0] pawe, padin, pbwe, pbdin;
  logic [AW-1:0] paaddr, pbaddr;

  initial begin
    do_reset();

    // Tie straight after reset: A first, then alternate.
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, '0, 4'd1, '0, 1'b1, '0, 4'd2, '0, ra, rb);
      seq = {seq[5:0], ra, rb};
    end
    check_eq("tie_seq", 32'(seq), 32'h99);

    cycle(1'b1, '1, 4'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, ra, rb);
    cycle(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0, ra, rb);
    check_eq("a_rd_ready", 32'(ra), 32'h1);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, ra, rb);
    check_eq("a_rd_data", obs_a_rdata, 32'hDEAD_BEEF);
    check_eq("a_rd_b_data", obs_b_rdata, 32'h0);

    cycle(1'b0, '0, '0, '0, 1'b1, '1, 4'd7, 32'hAAAA_AAAA, ra, rb);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h0000_FFFF, 4'd7, 32'h1234_5678, ra, rb);
    cycle(1'b1, '0, 4'd7, '0, 1'b0, '0, '0, '0, ra, rb);
    check_eq("b_wr_old", obs_b_rdata, 32'hAAAA_AAAA);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, ra, rb);
    check_eq("masked_rd", obs_a_rdata, 32'hAAAA_5678);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, '0, 4'd3, '0, 1'b0, '0, '0, '0, ra, rb);
      check_eq("a_only_ready", 32'(ra), 32'h1);
    end
    cycle(1'b1, '0, 4'd3, '0, 1'b1, '0, 4'd4, '0, ra, rb);
    check_eq("tie_after_a", 32'({ra, rb}), 32'h1);

    // Reset the cycle after a grant: response must vanish.
    cycle(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0, ra, rb);
    do_reset();
    cycle(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0, ra, rb);

    pav = 1'b0; pbv = 1'b0; ra = 1'b0; rb = 1'b0;
    pawe = '0; padin = '0; pbwe = '0; pbdin = '0; paaddr = '0; pbaddr = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pav || ra) begin
        pav    = ($urandom_range(0, 3) != 0);
        pawe   = $urandom_range(0, 1) ? '0 : DW'($urandom);
        paaddr = AW'($urandom_range(0, DEPTH - 1));
        padin  = DW'($urandom);
      end
      if (!pbv || rb) begin
        pbv    = ($urandom_range(0, 3) != 0);
        pbwe   = $urandom_range(0, 1) ? '0 : DW'($urandom);
        pbaddr = AW'($urandom_range(0, DEPTH - 1));
        pbdin  = DW'($urandom);
      end
      cycle(pav, pawe, paaddr, padin, pbv, pbwe, pbaddr, pbdin, ra, rb);
    end
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, ra, rb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
